mod503_mult_seq: RTL and testbench

Sequential modular multiplier for the mod-503 datapath. It computes (a·b) mod 503 for two 9-bit operands by time-sharing one external combinational 3×3 digit multiplier over the nine base-8 digit pairs, then folds the 18-bit accumulator back to a canonical residue. It sits between the operand source and the residue consumer, and uses valid/ready handshakes on both sides.

---
 rtl/mod503_mult_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_mod503_mult_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod503_mult_seq.sv
// mod503_mult_seq
// ----------------------------------------------------------------------------
// Sequential modular multiplier: out_res = (in_a * in_b) mod 503.
//
// The 9-bit operands are split into three base-8 digits each. One external
// combinational 3x3 digit multiplier is time-shared over the nine digit pairs,
// and each partial product is shifted and added into an 18-bit accumulator.
// Two folding steps use 512 == 9 (mod 503) to shrink the accumulator, and a
// final conditional subtract yields the canonical residue 0..502.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  operand pair valid
//   in_ready   out  1  idle and able to accept an operand pair
//   in_a       in   9  operand a
//   in_b       in   9  operand b
//   dm_x       out  6  digit multiplier operands {b_digit, a_digit}, 0 outside MAC
//   dm_p       in   6  digit product, returned combinationally in the same cycle
//   out_valid  out  1  result valid, held until accepted
//   out_ready  in   1  consumer accepts the result
//   out_res    out  9  residue, 0..502
//   out_err    out  1  an operand was >= 503 (range-check build only)
//
// Build option
//   MOD503_RANGE_CHECK_EN  when defined, out_err reports (in_a >= 503) |
//                          (in_b >= 503) latched at acceptance. When not
//                          defined, out_err is tied low and no comparators
//                          exist. The residue is identical in both builds.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_ready does not depend on in_valid; out_valid does not depend on
// out_ready. Once out_valid is raised, out_res/out_err stay stable until the
// transfer.
// ----------------------------------------------------------------------------
module mod503_mult_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] in_a,
    input  logic [8:0] in_b,
    output logic [5:0] dm_x,
    input  logic [5:0] dm_p,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] out_res,
    output logic       out_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAC  = 3'd1,
        S_RED1 = 3'd2,
        S_RED2 = 3'd3,
        S_CORR = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t      state, state_nxt;

    // alive_q keeps in_ready low while reset is asserted and rises on the
    // first clock edge after release.
    logic        alive_q;

    logic [8:0]  a_q, a_nxt;
    logic [8:0]  b_q, b_nxt;
    logic [17:0] acc, acc_nxt;
    // Digit indices: i walks the a digits (inner), j walks the b digits.
    logic [1:0]  i_q, i_nxt;
    logic [1:0]  j_q, j_nxt;
    logic [8:0]  res_q, res_nxt;

    logic        accept;
    logic [2:0]  a_dig;
    logic [2:0]  b_dig;
    logic [2:0]  shift_sel;
    logic [17:0] addend;
    logic [12:0] fold1;
    logic [9:0]  fold2;
    logic [9:0]  corr_diff;

    assign in_ready  = alive_q && (state == S_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);
    assign out_res   = res_q;

    // ------------------------------------------------------------------
    // Digit selection for the current (i, j) pair.
    // ------------------------------------------------------------------
    always_comb begin
        a_dig = a_q[8:6];
        case (i_q)
            2'd0:    a_dig = a_q[2:0];
            2'd1:    a_dig = a_q[5:3];
            default: a_dig = a_q[8:6];
        endcase
    end

    always_comb begin
        b_dig = b_q[8:6];
        case (j_q)
            2'd0:    b_dig = b_q[2:0];
            2'd1:    b_dig = b_q[5:3];
            default: b_dig = b_q[8:6];
        endcase
    end

    assign dm_x = (state == S_MAC) ? {b_dig, a_dig} : 6'd0;

    // Partial product weight is 8^(i+j), i.e. a shift of 3*(i+j) bits.
    assign shift_sel = {1'b0, i_q} + {1'b0, j_q};

    always_comb begin
        addend = {dm_p, 12'd0};
        case (shift_sel)
            3'd0:    addend = {12'd0, dm_p};
            3'd1:    addend = {9'd0, dm_p, 3'd0};
            3'd2:    addend = {6'd0, dm_p, 6'd0};
            3'd3:    addend = {3'd0, dm_p, 9'd0};
            default: addend = {dm_p, 12'd0};
        endcase
    end

    // ------------------------------------------------------------------
    // Folding: high part * 512 is replaced by high part * 9 (= 8x + x).
    // acc <= 511*511 so fold1 <= 5101 (13 bits); fold2 <= 592 (10 bits).
    // ------------------------------------------------------------------
    assign fold1 = ({4'd0, acc[17:9]} << 3) + {4'd0, acc[17:9]} + {4'd0, acc[8:0]};
    assign fold2 = ({6'd0, acc[12:9]} << 3) + {6'd0, acc[12:9]} + {1'b0, acc[8:0]};

    // fold2 <= 592 < 2*503, so one conditional subtract is enough.
    assign corr_diff = acc[9:0] - 10'd503;

    // ------------------------------------------------------------------
    // Next-state and datapath update.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        acc_nxt   = acc;
        i_nxt     = i_q;
        j_nxt     = j_q;
        res_nxt   = res_q;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    a_nxt     = in_a;
                    b_nxt     = in_b;
                    acc_nxt   = 18'd0;
                    i_nxt     = 2'd0;
                    j_nxt     = 2'd0;
                    state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                acc_nxt = acc + addend;
                if (i_q == 2'd2) begin
                    i_nxt = 2'd0;
                    if (j_q == 2'd2) begin
                        j_nxt     = 2'd0;
                        state_nxt = S_RED1;
                    end else begin
                        j_nxt = j_q + 2'd1;
                    end
                end else begin
                    i_nxt = i_q + 2'd1;
                end
            end
            S_RED1: begin
                acc_nxt   = {5'd0, fold1};
                state_nxt = S_RED2;
            end
            S_RED2: begin
                acc_nxt   = {8'd0, fold2};
                state_nxt = S_CORR;
            end
            S_CORR: begin
                res_nxt   = (acc[9:0] >= 10'd503) ? corr_diff[8:0] : acc[8:0];
                state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            alive_q <= 1'b0;
            a_q     <= 9'd0;
            b_q     <= 9'd0;
            acc     <= 18'd0;
            i_q     <= 2'd0;
            j_q     <= 2'd0;
            res_q   <= 9'd0;
        end else begin
            state   <= state_nxt;
            alive_q <= 1'b1;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            acc     <= acc_nxt;
            i_q     <= i_nxt;
            j_q     <= j_nxt;
            res_q   <= res_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Operand range flag.
    // ------------------------------------------------------------------
`ifdef MOD503_RANGE_CHECK_EN
    logic err_in_q;
    logic err_q;

    // Flag is captured with the operands and moved to the output register
    // together with the residue, so both change at the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_in_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                err_in_q <= (in_a >= 9'd503) || (in_b >= 9'd503);
            end
            if (state == S_CORR) begin
                err_q <= err_in_q;
            end
        end
    end

    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_mod503_mult_seq.sv
module tb_mod503_mult_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] in_a = 9'd0;
  logic [8:0] in_b = 9'd0;
  logic [5:0] dm_x;
  logic [5:0] dm_p;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [8:0] out_res;
  logic       out_err;

  int checks = 0;
  int fails = 0;
  int cycle = 0;

  logic ready_rand = 1'b0;
  logic ready_force = 1'b1;
  logic prev_valid = 1'b0;

  logic [9:0] exp_q[$];
  int         edge_q[$];

  mod503_mult_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .dm_x      (dm_x),
    .dm_p      (dm_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_err   (out_err)
  );

  // ---------------- clock / external digit multiplier ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  assign dm_p = {3'd0, dm_x[5:3]} * {3'd0, dm_x[2:0]};

  always @(posedge clk) begin
    #2;
    out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // ---------------- reference model and check helper ----------------
  function automatic logic [9:0] ref_model(input int a, input int b);
    int   r;
    logic e;
    r = (a * b) % 503;
    e = 1'b0;
`ifdef MOD503_RANGE_CHECK_EN
    e = (a >= 503) || (b >= 503);
`endif
    return {e, r[8:0]};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input int a, input int b);
    int guard;
    guard = 0;
    in_a = a[8:0];
    in_b = b[8:0];
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: in_ready stayed 0 for a=%0d b=%0d", a, b);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(ref_model(a, b));
      edge_q.push_back(cycle + 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [9:0] head;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_result: out_valid=1 with res %0d, expected no result", out_res);
        end else begin
          head = exp_q[0];
          if (!prev_valid) check("latency", cycle - edge_q[0], 12);
          check("in_ready_in_done", in_ready, 0);
          check("out_res", out_res, head[8:0]);
          check("out_err", out_err, head[9]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(edge_q.pop_front());
          end
        end
      end
      prev_valid = out_valid && !out_ready;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int a_val;
    int b_val;
    int exp_dm;
    int guard;
    int sel;

    // reset state
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_res", out_res, 0);
    check("rst_out_err", out_err, 0);
    check("rst_dm_x", dm_x, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_release", in_ready, 1);
    @(posedge clk);
    #1;

    // 502 * 502 with digit-pair walk
    a_val = 502;
    b_val = 502;
    send(a_val, b_val);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      exp_dm = (((b_val >> (3 * (k / 3))) & 7) * 8) + ((a_val >> (3 * (k % 3))) & 7);
      check($sformatf("dm_x_k%0d", k), dm_x, exp_dm);
    end
    @(negedge clk);
    check("dm_x_after_mac", dm_x, 0);
    @(posedge clk);
    #1;

    // directed values
    send(0, 377);
    send(2, 252);
    send(256, 2);
    send(511, 1);
    drain();

    // backpressure with an ignored in_valid pulse
    ready_force = 1'b0;
    send(100, 100);
    guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("bp_result_arrives", out_valid, 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        in_a = 9'd7;
        in_b = 9'd9;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("bp_out_valid_held", out_valid, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ready_force = 1'b1;
    drain();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check("bp_pulse_ignored", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // reset in the middle of MAC
    send(40, 50);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_res", out_res, 0);
    check("midrst_out_err", out_err, 0);
    check("midrst_dm_x", dm_x, 0);
    exp_q.delete();
    edge_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(3, 5);
    drain();

    // random sweep with random out_ready stalls
    ready_rand = 1'b1;
    for (int n = 0; n < 2500; n++) begin
      a_val = $urandom_range(0, 511);
      b_val = $urandom_range(0, 511);
      sel = $urandom_range(0, 15);
      if (sel == 0) a_val = 502;
      if (sel == 1) b_val = 503;
      if (sel == 2) a_val = 511;
      if (sel == 3) b_val = 0;
      send(a_val, b_val);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    ready_rand = 1'b0;
    ready_force = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
